// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 classic arbiter: N_MASTERS masters share one slave port.
// Grants are locked for a whole bus cycle; a per-transfer watchdog forces ERR on hung slaves.
module wb_rr_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MASTERS-1:0]      m_cyc_i,
  input  logic [N_MASTERS-1:0]      m_stb_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS*AW-1:0]   m_adr_i,
  input  logic [N_MASTERS*DW-1:0]   m_dat_i,
  input  logic [N_MASTERS*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [N_MASTERS-1:0]      m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [N_MASTERS-1:0]      gnt_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WdMax  = CW'(TIMEOUT);
  localparam logic [PW-1:0] PtrRst = PW'(N_MASTERS - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [CW-1:0]        wd_q, wd_d;
  logic                 busy;
  logic                 wd_expire;
  logic                 slv_rsp;
  logic                 found;

  assign busy      = (state_q == StBusy);
  assign slv_rsp   = s_ack_i | s_err_i;
  assign wd_expire = (TIMEOUT > 0) && busy && (wd_q == WdMax);
  assign gnt_o     = gnt_q;
  assign m_dat_o   = s_dat_i;

  // Next-state: round-robin pick in IDLE, hold grant until the owner drops CYC.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    found   = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
          int unsigned idx;
          idx = (int'(ptr_q) + i) % N_MASTERS;
          if (!found && m_cyc_i[idx]) begin
            found      = 1'b1;
            gidx_d     = PW'(idx);
            gnt_d      = '0;
            gnt_d[idx] = 1'b1;
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        if (!m_cyc_i[gidx_q]) begin
          ptr_d   = gidx_q;
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave-side mux and response routing to the granted master only.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[gidx_q];
      // STB is masked on expiry regardless of the slave, avoiding an ACK->STB comb path.
      s_stb_o = m_stb_i[gidx_q] & ~wd_expire;
      s_we_o  = m_we_i[gidx_q];
      s_adr_o = m_adr_i[int'(gidx_q)*AW +: AW];
      s_dat_o = m_dat_i[int'(gidx_q)*DW +: DW];
      s_sel_o = m_sel_i[int'(gidx_q)*SW +: SW];
      m_ack_o[gidx_q] = s_ack_i;
      // A real slave response in the expiry cycle wins over the watchdog.
      m_err_o[gidx_q] = s_err_i | (wd_expire & ~s_ack_i);
    end
  end

  // Watchdog: counts STB cycles without a response, saturating at TIMEOUT.
  always_comb begin
    wd_d = wd_q;
    if ((TIMEOUT == 0) || !busy || !s_stb_o || slv_rsp) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= PtrRst;
      gidx_q  <= '0;
      gnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with grant/data scoreboards.
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*DW/8-1:0] m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, gnt_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i;

  int checks   = 0;
  int failures = 0;
  int          exp_gnt_q[$];
  logic [63:0] exp_dat_q[$];

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .N_MASTERS(N),
    .AW       (AW),
    .DW       (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_cyc_i(m_cyc_i),
    .m_stb_i(m_stb_i),
    .m_we_i (m_we_i),
    .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i),
    .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o),
    .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o),
    .s_we_o (s_we_o),
    .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i),
    .s_err_i(s_err_i),
    .gnt_o  (gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, output int g);
    logic [63:0] e;
    g = -1;
    e = 64'hdead;
    if (exp_gnt_q.size() > 0) begin
      g = exp_gnt_q.pop_front();
      e = 64'(1) << g;
    end
    chk(tag, 64'(gnt_o), e);
  endtask

  task automatic chk_dat(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = 64'hbad0_bad0_bad0_bad0;
    if (exp_dat_q.size() > 0) e = exp_dat_q.pop_front();
    chk(tag, obs, e);
  endtask

  initial begin
    int g;
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '1;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_scyc", 64'(s_cyc_o), 0);
    chk("rst_sstb", 64'(s_stb_o), 0);
    chk("rst_ack", 64'(m_ack_o), 0);
    chk("rst_err", 64'(m_err_o), 0);
    rst = 1'b0;

    // 1: single read by master 0, ACK on the second STB cycle.
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    m_adr_i[0*AW +: AW] = 32'h0000_0100;
    exp_gnt_q.push_back(0);
    settle();
    chk("t1_gnt_pre", 64'(gnt_o), 0);
    chk("t1_scyc_pre", 64'(s_cyc_o), 0);
    tick();
    chk_gnt("t1_gnt", g);
    chk("t1_scyc", 64'(s_cyc_o), 1);
    chk("t1_sstb", 64'(s_stb_o), 1);
    chk("t1_sadr", 64'(s_adr_o), 64'h100);
    chk("t1_ack_early", 64'(m_ack_o), 0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hdead_beef;
    exp_dat_q.push_back(64'hdead_beef);
    settle();
    chk("t1_ack", 64'(m_ack_o), 4'b0001);
    chk_dat("t1_rdata", 64'(m_dat_o));
    tick();
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    settle();
    chk("t1_ack_off", 64'(m_ack_o), 0);
    chk("t1_scyc_rel", 64'(s_cyc_o), 0);
    chk("t1_gnt_rel", 64'(gnt_o), 4'b0001);
    tick();
    chk("t1_gnt_idle", 64'(gnt_o), 0);

    // 2: all masters request; one beat each, re-raising CYC after release.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
    foreach (exp_gnt_q[i]) exp_gnt_q.delete(i);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_gnt("t2_gnt", g);
      if (g < 0) g = 0;
      s_ack_i = 1'b1;
      settle();
      chk("t2_ack", 64'(m_ack_o), 64'(1) << g);
      tick();
      s_ack_i = 1'b0; m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
      settle();
      chk("t2_scyc_rel", 64'(s_cyc_o), 0);
      tick();
      chk("t2_idle_gap", 64'(gnt_o), 0);
      if (k < 4) begin
        m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
      end
    end
    m_cyc_i = '0; m_stb_i = '0;

    // 3: master 2 holds a 4-beat write burst while master 1 waits.
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100; m_we_i = 4'b0100;
    exp_gnt_q.push_back(2);
    tick();
    chk_gnt("t3_gnt2", g);
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_dat_i[2*DW +: DW] = 32'ha000_0000 + b;
      m_adr_i[2*AW +: AW] = 32'h200 + 4 * b;
      exp_dat_q.push_back(64'(32'ha000_0000 + b));
      s_ack_i = 1'b1;
      settle();
      chk("t3_gnt_hold", 64'(gnt_o), 4'b0100);
      chk("t3_ack", 64'(m_ack_o), 4'b0100);
      chk("t3_we", 64'(s_we_o), 1);
      chk_dat("t3_wdata", 64'(s_dat_o));
      tick();
    end
    s_ack_i = 1'b0; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0; m_we_i = '0;
    exp_gnt_q.push_back(1);
    settle();
    chk("t3_gnt_still", 64'(gnt_o), 4'b0100);
    tick();
    chk("t3_idle", 64'(gnt_o), 0);
    tick();
    chk_gnt("t3_gnt1", g);
    m_cyc_i = '0; m_stb_i = '0;
    tick();
    tick();

    // 4: slave never answers master 0; watchdog fires 8 cycles after STB.
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    exp_gnt_q.push_back(0);
    tick();
    chk_gnt("t4_gnt", g);
    for (int c = 0; c < 8; c++) begin
      chk("t4_noerr", 64'(m_err_o), 0);
      chk("t4_stb", 64'(s_stb_o), 1);
      tick();
    end
    chk("t4_err", 64'(m_err_o), 4'b0001);
    chk("t4_stb_masked", 64'(s_stb_o), 0);
    tick();
    chk("t4_err_once", 64'(m_err_o), 0);
    chk("t4_stb_back", 64'(s_stb_o), 1);
    chk("t4_gnt_kept", 64'(gnt_o), 4'b0001);

    // 5: ACK lands exactly on the expiry cycle; the slave wins.
    for (int c = 0; c < 8; c++) tick();
    s_ack_i = 1'b1;
    settle();
    chk("t5_ack", 64'(m_ack_o), 4'b0001);
    chk("t5_noerr", 64'(m_err_o), 0);
    tick();
    s_ack_i = 1'b0;
    settle();
    chk("t5_err_after", 64'(m_err_o), 0);
    m_cyc_i = '0; m_stb_i = '0;
    tick();

    // 6: master 3 busy; ACK+ERR pass-through, then reset mid-transfer.
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    exp_gnt_q.push_back(3);
    tick();
    chk_gnt("t6_gnt3", g);
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    settle();
    chk("t6_ack_both", 64'(m_ack_o), 4'b1000);
    chk("t6_err_both", 64'(m_err_o), 4'b1000);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_gnt", 64'(gnt_o), 0);
    chk("t6_rst_scyc", 64'(s_cyc_o), 0);
    chk("t6_rst_ack", 64'(m_ack_o), 0);
    chk("t6_rst_err", 64'(m_err_o), 0);
    exp_gnt_q.push_back(0);
    tick();
    chk_gnt("t6_gnt0", g);
    chk("t6_gnt_q_empty", 64'(exp_gnt_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
